// File: rtl/cluster_clkgate_ctrl.sv
// Per-channel clock-gate enable sequencer: OFF -> WAKE -> ON -> IDLE -> OFF, with wake delay and idle hysteresis.
// clk_en/ack are decoded from registered state only; ack follows clk_en by WAKE_CYCLES edges; no backpressure.
module cluster_clkgate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_en_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] force_on_i,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic [NUM_CH-1:0] ack_o,
  output logic              all_off_o
);

  localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_WAKE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd3;

  localparam logic [CW-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? CW'(WAKE_CYCLES - 1) : CW'(0);
  localparam logic [CW-1:0] IDLE_LOAD = (IDLE_CYCLES > 0) ? CW'(IDLE_CYCLES - 1) : CW'(0);

  logic [1:0]        state_q [NUM_CH];
  logic [1:0]        state_d [NUM_CH];
  logic [CW-1:0]     cnt_q   [NUM_CH];
  logic [CW-1:0]     cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] act;
  logic [NUM_CH-1:0] fsm_en;
  logic [NUM_CH-1:0] fsm_ack;
  logic [NUM_CH-1:0] fsm_off;

  assign act = req_i | force_on_i;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        ST_OFF: begin
          if (act[c]) begin
            state_d[c] = (WAKE_CYCLES == 0) ? ST_ON : ST_WAKE;
            cnt_d[c]   = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          // Wake is never aborted: the gate cell must settle before we report ack.
          if (cnt_q[c] == '0) begin
            state_d[c] = ST_ON;
          end else begin
            cnt_d[c] = cnt_q[c] - CW'(1);
          end
        end
        ST_ON: begin
          if (!act[c]) begin
            state_d[c] = (IDLE_CYCLES == 0) ? ST_OFF : ST_IDLE;
            cnt_d[c]   = IDLE_LOAD;
          end
        end
        default: begin
          if (act[c]) begin
            state_d[c] = ST_ON;
          end else if (cnt_q[c] == '0) begin
            state_d[c] = ST_OFF;
          end else begin
            cnt_d[c] = cnt_q[c] - CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst_i) begin
        state_q[c] <= ST_OFF;
        cnt_q[c]   <= '0;
      end else begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  always_comb begin
    fsm_en  = '0;
    fsm_ack = '0;
    fsm_off = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fsm_en[c]  = (state_q[c] != ST_OFF);
      fsm_ack[c] = (state_q[c] == ST_ON) || (state_q[c] == ST_IDLE);
      fsm_off[c] = (state_q[c] == ST_OFF);
    end
  end

  // Test override only touches the enable path, never state or ack.
  assign clk_en_o  = fsm_en | {NUM_CH{test_en_i}};
  assign ack_o     = fsm_ack;
  assign all_off_o = &fsm_off;

endmodule
